// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the multi-cycle CPU control path: FSM state
// encoding, instruction opcode/funct values, ALU command encoding,
// register-destination and writeback-select encodings, and the decoded
// instruction bundle passed from ctrl_decode to multicycle_ctrl.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC,
        ALU_WB,
        ADDR,
        MEM_RD,
        LW_WB,
        MEM_WR,
        BRANCH,
        JUMP,
        NOPRET,
        TRAP
    } state_t;

    // Instruction classes resolved once in DECODE and held until retire.
    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BEQ,
        CLS_BNE,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_ILLEGAL
    } instr_class_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_XOR = 3'b010,
        ALU_SLT = 3'b011
    } alu_op_t;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    // Register file destination select
    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    // Register file writeback source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef struct packed {
        instr_class_t cls;
        alu_op_t      alu_op;
        logic         alu_src_b;
        logic [1:0]   reg_dst;
    } decode_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Purely combinational instruction decoder.
// Ports:
//   opcode - IR[31:26]
//   funct  - IR[5:0], only meaningful for R-type
//   dec    - instruction class plus the ALU command, ALU B-operand select
//            and register destination that the instruction needs
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output decode_t    dec
);

    always_comb begin
        dec = '{cls: CLS_ILLEGAL, alu_op: ALU_ADD, alu_src_b: 1'b0, reg_dst: REG_DST_RT};
        case (opcode)
            OP_RTYPE: begin
                dec.reg_dst = REG_DST_RD;
                case (funct)
                    FN_ADD: begin dec.cls = CLS_ALU_R; dec.alu_op = ALU_ADD; end
                    FN_SUB: begin dec.cls = CLS_ALU_R; dec.alu_op = ALU_SUB; end
                    FN_SLT: begin dec.cls = CLS_ALU_R; dec.alu_op = ALU_SLT; end
                    FN_JR:  dec.cls = CLS_JR;
                    default: dec.cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI: begin
                dec.cls       = CLS_ALU_I;
                dec.alu_op    = ALU_ADD;
                dec.alu_src_b = 1'b1;
            end
            OP_XORI: begin
                dec.cls       = CLS_ALU_I;
                dec.alu_op    = ALU_XOR;
                dec.alu_src_b = 1'b1;
            end
            OP_LW: begin
                dec.cls       = CLS_LOAD;
                dec.alu_src_b = 1'b1;
            end
            OP_SW: begin
                dec.cls       = CLS_STORE;
                dec.alu_src_b = 1'b1;
            end
            OP_BEQ: begin
                dec.cls    = CLS_BEQ;
                dec.alu_op = ALU_SUB;
            end
            OP_BNE: begin
                dec.cls    = CLS_BNE;
                dec.alu_op = ALU_SUB;
            end
            OP_J:   dec.cls = CLS_J;
            OP_JAL: begin
                dec.cls     = CLS_JAL;
                dec.reg_dst = REG_DST_R31;
            end
            default: dec.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Control FSM of the multi-cycle CPU. Sequences fetch, decode, execute,
// memory access and writeback over one shared instruction/data memory.
// Parameters:
//   ILLEGAL_TRAP - 1: undecoded instruction enters sticky TRAP
//                  0: undecoded instruction retires as a NOP
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   opcode, funct       - instruction fields from the IR
//   zero                - ALU zero flag, used in BRANCH
//   mem_ready           - memory completes the current access this cycle
//   write_pc, is_branch, is_jump, jump_src - PC update controls
//   ir_we               - instruction register load
//   mem_rd, mem_we, mem_addr_sel - memory controls
//   reg_we, reg_dst, wb_sel      - register file controls
//   alu_src_b, alu_op   - ALU controls
//   retire              - one-cycle pulse per completed instruction
//   illegal             - high while in TRAP
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       write_pc,
    output logic       is_branch,
    output logic       is_jump,
    output logic       jump_src,
    output logic       ir_we,
    output logic       mem_rd,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic       alu_src_b,
    output logic [2:0] alu_op,
    output logic       retire,
    output logic       illegal
);

    localparam decode_t DEC_RESET = '{cls: CLS_ILLEGAL, alu_op: ALU_ADD,
                                      alu_src_b: 1'b0, reg_dst: REG_DST_RT};

    state_t  state_reg, state_next;
    decode_t dec_live;
    decode_t dec_reg, dec_next;

    ctrl_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .dec    (dec_live)
    );

    // State and latched decode register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FETCH;
            dec_reg   <= DEC_RESET;
        end else begin
            state_reg <= state_next;
            dec_reg   <= dec_next;
        end
    end

    // The IR is only guaranteed stable from DECODE on, so the class is
    // captured there and later states work from the latched copy.
    always_comb begin
        dec_next = dec_reg;
        if (state_reg == DECODE) begin
            dec_next = dec_live;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:  if (mem_ready) state_next = DECODE;
            DECODE: begin
                case (dec_live.cls)
                    CLS_ALU_R, CLS_ALU_I:    state_next = EXEC;
                    CLS_LOAD, CLS_STORE:     state_next = ADDR;
                    CLS_BEQ, CLS_BNE:        state_next = BRANCH;
                    CLS_J, CLS_JAL, CLS_JR:  state_next = JUMP;
                    default:                 state_next = ILLEGAL_TRAP ? TRAP : NOPRET;
                endcase
            end
            EXEC:   state_next = ALU_WB;
            ALU_WB: state_next = FETCH;
            ADDR:   state_next = (dec_reg.cls == CLS_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD: if (mem_ready) state_next = LW_WB;
            LW_WB:  state_next = FETCH;
            MEM_WR: if (mem_ready) state_next = FETCH;
            BRANCH: state_next = FETCH;
            JUMP:   state_next = FETCH;
            NOPRET: state_next = FETCH;
            TRAP:   state_next = TRAP;
            default: state_next = FETCH;
        endcase
    end

    // Output logic. Gated by reset so an aborted instruction cannot
    // produce a partial write in the reset cycle.
    always_comb begin
        write_pc     = 1'b0;
        is_branch    = 1'b0;
        is_jump      = 1'b0;
        jump_src     = 1'b0;
        ir_we        = 1'b0;
        mem_rd       = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        reg_we       = 1'b0;
        reg_dst      = REG_DST_RT;
        wb_sel       = WB_ALU;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        retire       = 1'b0;
        illegal      = 1'b0;
        if (!reset) begin
            case (state_reg)
                FETCH: begin
                    mem_rd = 1'b1;
                    ir_we  = mem_ready;
                end
                EXEC: begin
                    alu_op    = dec_reg.alu_op;
                    alu_src_b = dec_reg.alu_src_b;
                end
                ALU_WB: begin
                    alu_op    = dec_reg.alu_op;
                    alu_src_b = dec_reg.alu_src_b;
                    reg_we    = 1'b1;
                    reg_dst   = dec_reg.reg_dst;
                    wb_sel    = WB_ALU;
                    write_pc  = 1'b1;
                    retire    = 1'b1;
                end
                ADDR, MEM_RD, MEM_WR: begin
                    // Address computation stays on the ALU output while
                    // the memory access is outstanding.
                    alu_op    = ALU_ADD;
                    alu_src_b = 1'b1;
                    if (state_reg == MEM_RD) begin
                        mem_rd       = 1'b1;
                        mem_addr_sel = 1'b1;
                    end
                    if (state_reg == MEM_WR) begin
                        mem_we       = 1'b1;
                        mem_addr_sel = 1'b1;
                        write_pc     = mem_ready;
                        retire       = mem_ready;
                    end
                end
                LW_WB: begin
                    reg_we   = 1'b1;
                    reg_dst  = REG_DST_RT;
                    wb_sel   = WB_MEM;
                    write_pc = 1'b1;
                    retire   = 1'b1;
                end
                BRANCH: begin
                    alu_op    = ALU_SUB;
                    alu_src_b = 1'b0;
                    write_pc  = 1'b1;
                    retire    = 1'b1;
                    is_branch = ((dec_reg.cls == CLS_BEQ) &&  zero) ||
                                ((dec_reg.cls == CLS_BNE) && !zero);
                end
                JUMP: begin
                    write_pc = 1'b1;
                    is_jump  = 1'b1;
                    retire   = 1'b1;
                    jump_src = (dec_reg.cls == CLS_JR);
                    if (dec_reg.cls == CLS_JAL) begin
                        reg_we  = 1'b1;
                        reg_dst = REG_DST_R31;
                        wb_sel  = WB_PC4;
                    end
                end
                NOPRET: begin
                    write_pc = 1'b1;
                    retire   = 1'b1;
                end
                TRAP: illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Directed testbench for multicycle_ctrl. Two instances share stimulus:
// dut traps on illegal instructions, dut_nop retires them as NOPs.
// Each task starts at posedge+1 with the FSM in FETCH and leaves it there.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       write_pc, is_branch, is_jump, jump_src, ir_we, mem_rd, mem_we;
    logic       mem_addr_sel, reg_we, alu_src_b, retire, illegal;
    logic [1:0] reg_dst, wb_sel;
    logic [2:0] alu_op;

    logic       n_write_pc, n_is_branch, n_is_jump, n_jump_src, n_ir_we, n_mem_rd, n_mem_we;
    logic       n_mem_addr_sel, n_reg_we, n_alu_src_b, n_retire, n_illegal;
    logic [1:0] n_reg_dst, n_wb_sel;
    logic [2:0] n_alu_op;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .write_pc(write_pc), .is_branch(is_branch),
        .is_jump(is_jump), .jump_src(jump_src), .ir_we(ir_we), .mem_rd(mem_rd),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .reg_we(reg_we),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .retire(retire), .illegal(illegal)
    );

    multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) dut_nop (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .write_pc(n_write_pc), .is_branch(n_is_branch),
        .is_jump(n_is_jump), .jump_src(n_jump_src), .ir_we(n_ir_we), .mem_rd(n_mem_rd),
        .mem_we(n_mem_we), .mem_addr_sel(n_mem_addr_sel), .reg_we(n_reg_we),
        .reg_dst(n_reg_dst), .wb_sel(n_wb_sel), .alu_src_b(n_alu_src_b),
        .alu_op(n_alu_op), .retire(n_retire), .illegal(n_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] dut_outs();
        return {write_pc, is_branch, is_jump, jump_src, ir_we, mem_rd, mem_we,
                mem_addr_sel, reg_we, reg_dst, wb_sel, alu_src_b, alu_op, retire, illegal};
    endfunction

    function automatic logic [4:0] dut_enables();
        return {write_pc, reg_we, mem_we, mem_rd, ir_we};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int retires;
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (dut_outs() !== 19'd0) begin
                errors++; $display("FAIL reset_outs got %h expected 0", dut_outs());
            end
            next_cycle();
        end
        reset = 1'b0;
        retires = 0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            retires += int'(retire);
            if (c == 1) begin
                checks++;
                if (ir_we !== 1'b1 || mem_rd !== 1'b1 || write_pc !== 1'b0) begin
                    errors++; $display("FAIL add_fetch got ir_we=%b mem_rd=%b write_pc=%b expected 1 1 0", ir_we, mem_rd, write_pc);
                end
            end
            if (c == 3) begin
                checks++;
                if (alu_op !== 3'b000 || reg_we !== 1'b0 || write_pc !== 1'b0) begin
                    errors++; $display("FAIL add_exec got alu_op=%b reg_we=%b write_pc=%b expected 000 0 0", alu_op, reg_we, write_pc);
                end
            end
            if (c == 4) begin
                checks++;
                if (reg_we !== 1'b1 || reg_dst !== 2'd1 || alu_op !== 3'b000 || write_pc !== 1'b1 || wb_sel !== 2'd0) begin
                    errors++; $display("FAIL add_wb got reg_we=%b reg_dst=%0d alu_op=%b write_pc=%b wb_sel=%0d expected 1 1 000 1 0",
                                       reg_we, reg_dst, alu_op, write_pc, wb_sel);
                end
            end
            next_cycle();
        end
        checks++;
        if (retires != 1) begin
            errors++; $display("FAIL add_retire_count got %0d expected 1", retires);
        end
        $display("ADD after reset: retires=%0d", retires);
    endtask

    task automatic test_alu();
        logic [5:0] t_op  [4] = '{6'h00, 6'h00, 6'h08, 6'h0e};
        logic [5:0] t_fn  [4] = '{6'h22, 6'h2a, 6'h00, 6'h00};
        logic [2:0] t_alu [4] = '{3'b001, 3'b011, 3'b000, 3'b010};
        logic       t_srcb[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0] t_dst [4] = '{2'd1, 2'd1, 2'd0, 2'd0};
        for (int i = 0; i < 4; i++) begin
            opcode = t_op[i]; funct = t_fn[i]; mem_ready = 1'b1;
            for (int c = 1; c <= 4; c++) begin
                #1;
                if (c == 4) begin
                    checks++;
                    if (alu_op !== t_alu[i] || alu_src_b !== t_srcb[i] || reg_dst !== t_dst[i] ||
                        reg_we !== 1'b1 || write_pc !== 1'b1 || retire !== 1'b1) begin
                        errors++; $display("FAIL alu_%0d got alu_op=%b src_b=%b reg_dst=%0d reg_we=%b write_pc=%b retire=%b expected %b %b %0d 1 1 1",
                                           i, alu_op, alu_src_b, reg_dst, reg_we, write_pc, retire, t_alu[i], t_srcb[i], t_dst[i]);
                    end
                end
                next_cycle();
            end
            $display("ALU op=%h funct=%h alu_op=%b", t_op[i], t_fn[i], t_alu[i]);
        end
    endtask

    task automatic test_lw();
        int rd_cycles;
        int wpc;
        opcode = 6'h23; funct = 6'h00;
        rd_cycles = 0; wpc = 0;
        for (int c = 1; c <= 7; c++) begin
            mem_ready = (c == 4 || c == 5) ? 1'b0 : 1'b1;
            #1;
            if (mem_rd && mem_addr_sel) rd_cycles++;
            wpc += int'(write_pc);
            if (c == 3) begin
                checks++;
                if (alu_op !== 3'b000 || alu_src_b !== 1'b1) begin
                    errors++; $display("FAIL lw_addr got alu_op=%b src_b=%b expected 000 1", alu_op, alu_src_b);
                end
            end
            if (c == 7) begin
                checks++;
                if (reg_we !== 1'b1 || wb_sel !== 2'd1 || reg_dst !== 2'd0 || write_pc !== 1'b1 || mem_rd !== 1'b0) begin
                    errors++; $display("FAIL lw_wb got reg_we=%b wb_sel=%0d reg_dst=%0d write_pc=%b mem_rd=%b expected 1 1 0 1 0",
                                       reg_we, wb_sel, reg_dst, write_pc, mem_rd);
                end
            end
            next_cycle();
        end
        checks++;
        if (rd_cycles != 3 || wpc != 1) begin
            errors++; $display("FAIL lw_counts got rd_cycles=%0d write_pc_cycles=%0d expected 3 1", rd_cycles, wpc);
        end
        $display("LW with 2 wait states: rd_cycles=%0d", rd_cycles);
    endtask

    task automatic test_branch(input logic [5:0] op, input logic z, input logic exp_br);
        opcode = op; funct = 6'h00; zero = z; mem_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            if (c == 3) begin
                checks++;
                if (is_branch !== exp_br || write_pc !== 1'b1 || retire !== 1'b1 || alu_op !== 3'b001 || alu_src_b !== 1'b0) begin
                    errors++; $display("FAIL branch_op%h_z%b got is_branch=%b write_pc=%b retire=%b alu_op=%b src_b=%b expected %b 1 1 001 0",
                                       op, z, is_branch, write_pc, retire, alu_op, alu_src_b, exp_br);
                end
            end
            next_cycle();
        end
        zero = 1'b0;
        $display("BRANCH op=%h zero=%b is_branch expected %b", op, z, exp_br);
    endtask

    task automatic test_jump();
        opcode = 6'h03; funct = 6'h00; mem_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            if (c == 3) begin
                checks++;
                if (is_jump !== 1'b1 || jump_src !== 1'b0 || reg_we !== 1'b1 || reg_dst !== 2'd2 ||
                    wb_sel !== 2'd2 || write_pc !== 1'b1) begin
                    errors++; $display("FAIL jal got is_jump=%b jump_src=%b reg_we=%b reg_dst=%0d wb_sel=%0d write_pc=%b expected 1 0 1 2 2 1",
                                       is_jump, jump_src, reg_we, reg_dst, wb_sel, write_pc);
                end
            end
            next_cycle();
        end
        $display("JAL checked");
        opcode = 6'h00; funct = 6'h08;
        for (int c = 1; c <= 3; c++) begin
            #1;
            if (c == 3) begin
                checks++;
                if (is_jump !== 1'b1 || jump_src !== 1'b1 || reg_we !== 1'b0 || write_pc !== 1'b1) begin
                    errors++; $display("FAIL jr got is_jump=%b jump_src=%b reg_we=%b write_pc=%b expected 1 1 0 1",
                                       is_jump, jump_src, reg_we, write_pc);
                end
            end
            next_cycle();
        end
        $display("JR checked");
    endtask

    task automatic test_sw();
        opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            if (c == 4) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr_sel !== 1'b1 || write_pc !== 1'b1 || retire !== 1'b1 || reg_we !== 1'b0) begin
                    errors++; $display("FAIL sw got mem_we=%b addr_sel=%b write_pc=%b retire=%b reg_we=%b expected 1 1 1 1 0",
                                       mem_we, mem_addr_sel, write_pc, retire, reg_we);
                end
            end
            next_cycle();
        end
        $display("SW zero wait checked");
    endtask

    task automatic test_sw_reset();
        int wpc;
        opcode = 6'h2b; funct = 6'h00; wpc = 0;
        for (int c = 1; c <= 5; c++) begin
            mem_ready = (c >= 4) ? 1'b0 : 1'b1;
            reset = (c == 5) ? 1'b1 : 1'b0;
            #1;
            wpc += int'(write_pc);
            if (c == 4) begin
                checks++;
                if (mem_we !== 1'b1 || write_pc !== 1'b0) begin
                    errors++; $display("FAIL sw_wait got mem_we=%b write_pc=%b expected 1 0", mem_we, write_pc);
                end
            end
            if (c == 5) begin
                checks++;
                if (dut_outs() !== 19'd0) begin
                    errors++; $display("FAIL sw_reset_outs got %h expected 0", dut_outs());
                end
            end
            next_cycle();
        end
        reset = 1'b0; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h20;
        #1;
        checks++;
        if (ir_we !== 1'b1 || mem_rd !== 1'b1 || mem_addr_sel !== 1'b0 || mem_we !== 1'b0 || wpc != 0) begin
            errors++; $display("FAIL sw_reset_fetch got ir_we=%b mem_rd=%b addr_sel=%b mem_we=%b write_pc_cycles=%0d expected 1 1 0 0 0",
                               ir_we, mem_rd, mem_addr_sel, mem_we, wpc);
        end
        // Let the ADD fetched here finish so the next task starts in FETCH.
        for (int c = 1; c <= 4; c++) next_cycle();
        $display("SW aborted by reset during wait");
    endtask

    task automatic test_trap();
        int bad;
        opcode = 6'h3f; funct = 6'h00; mem_ready = 1'b1;
        bad = 0;
        for (int c = 1; c <= 14; c++) begin
            #1;
            if (c == 2) begin
                checks++;
                if (illegal !== 1'b0) begin
                    errors++; $display("FAIL trap_early got illegal=%b expected 0", illegal);
                end
            end
            if (c == 3) begin
                checks++;
                if (n_write_pc !== 1'b1 || n_retire !== 1'b1 || n_illegal !== 1'b0) begin
                    errors++; $display("FAIL nopret got write_pc=%b retire=%b illegal=%b expected 1 1 0", n_write_pc, n_retire, n_illegal);
                end
            end
            if (c == 4) begin
                checks++;
                if (n_ir_we !== 1'b1 || n_mem_rd !== 1'b1) begin
                    errors++; $display("FAIL nopret_fetch got ir_we=%b mem_rd=%b expected 1 1", n_ir_we, n_mem_rd);
                end
            end
            if (c >= 3 && (illegal !== 1'b1 || dut_enables() !== 5'd0 || retire !== 1'b0)) bad++;
            next_cycle();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL trap_sticky got %0d bad cycles expected 0", bad);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (illegal !== 1'b0) begin
            errors++; $display("FAIL trap_reset got illegal=%b expected 0", illegal);
        end
        next_cycle();
        reset = 1'b0; opcode = 6'h00; funct = 6'h20;
        #1;
        checks++;
        if (illegal !== 1'b0 || ir_we !== 1'b1) begin
            errors++; $display("FAIL trap_release got illegal=%b ir_we=%b expected 0 1", illegal, ir_we);
        end
        $display("TRAP sticky for 12 cycles, cleared by reset");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_lw();
        test_branch(6'h04, 1'b1, 1'b1);
        test_branch(6'h04, 1'b0, 1'b0);
        test_branch(6'h05, 1'b1, 1'b0);
        test_branch(6'h05, 1'b0, 1'b1);
        test_jump();
        test_sw();
        test_sw_reset();
        test_trap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
